pipe_stall_ctrl: RTL and testbench

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

---
 rtl/pipe_stall_ctrl.sv | 129 ++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Hazard and stall controller for a 5-stage pipeline.
// It handles load-use interlocks, branch flushes, memory-wait freezes, and a sticky memory timeout error.
module pipe_stall_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             mem_err,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_next;
    logic              lu;
    logic              ms;
    logic              freeze;

    assign lu = ex_mem_read && (ex_rt != 5'd0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    assign ms = mem_req && !mem_ready;

    // In MEM_WAIT only mem_ready matters: the frozen MEM stage still holds the access.
    assign freeze = (state == ERR) ||
                    ((state == RUN) && ms) ||
                    ((state == MEM_WAIT) && !mem_ready);

    assign wait_next = wait_cnt + WAIT_W'(1);
    assign fsm_state = state;

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        if (freeze) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (branch_taken) begin
            // A taken branch kills the dependent instruction, so the LU stall is not needed.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (lu) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (ms) begin
                        wait_cnt <= WAIT_W'(1);
                        if (MEM_TIMEOUT <= 1) begin
                            state   <= ERR;
                            mem_err <= 1'b1;
                        end else begin
                            state <= MEM_WAIT;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (!mem_ready) begin
                        wait_cnt <= wait_next;
                        if (wait_next >= WAIT_W'(MEM_TIMEOUT)) begin
                            state   <= ERR;
                            mem_err <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= '0;
                        state    <= RUN;
                    end
                end
                ERR: begin
                    mem_err <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (!pc_en && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl with MEM_TIMEOUT=4 and CNT_W=4.
// Each step drives one cycle of inputs and queues the hand-computed outputs, and the monitor checks them later in that cycle.
module tb_pipe_stall_ctrl;

    localparam int W = 14;
    // Output group order: {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush}
    localparam logic [6:0] O_RUN = 7'b1111_000;
    localparam logic [6:0] O_MS  = 7'b0000_001;
    localparam logic [6:0] O_BR  = 7'b1111_110;
    localparam logic [6:0] O_LU  = 7'b0011_010;
    localparam logic [1:0] S_RUN = 2'd0;
    localparam logic [1:0] S_MW  = 2'd1;
    localparam logic [1:0] S_ERR = 2'd2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic       id_uses_rt = 1'b0, ex_mem_read = 1'b0, branch_taken = 1'b0;
    logic       mem_req = 1'b0, mem_ready = 1'b0;
    logic       pc_en, ifid_en, idex_en, exmem_en;
    logic       ifid_flush, idex_flush, memwb_flush;
    logic [3:0] stall_cycles;
    logic       mem_err;
    logic [1:0] fsm_state;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    pipe_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
        .stall_cycles(stall_cycles), .mem_err(mem_err), .fsm_state(fsm_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish before 100000");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                        input logic uses, input logic mr, input logic [4:0] ert,
                        input logic br, input logic mq, input logic rdy,
                        input logic [6:0] o, input logic [1:0] st,
                        input logic err, input logic [3:0] stl);
        @(negedge clk);
        rst_n        = r;
        id_rs        = rs;
        id_rt        = rt;
        id_uses_rt   = uses;
        ex_mem_read  = mr;
        ex_rt        = ert;
        branch_taken = br;
        mem_req      = mq;
        mem_ready    = rdy;
        exp_q.push_back({st, err, stl, o});
    endtask

    task automatic idle(input logic r, input logic [1:0] st, input logic err, input logic [3:0] stl);
        step(r, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_RUN, st, err, stl);
    endtask

    task automatic mem_stall(input logic [6:0] o, input logic [1:0] st, input logic err, input logic [3:0] stl);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, o, st, err, stl);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] e, g;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {fsm_state, mem_err, stall_cycles, pc_en, ifid_en, idex_en, exmem_en,
                 ifid_flush, idex_flush, memwb_flush};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL cycle_check #%0d at %0t: got st=%0d err=%b stall=%0d en/fl=%b, want st=%0d err=%b stall=%0d en/fl=%b",
                         checks, $time, g[13:12], g[11], g[10:7], g[6:0],
                         e[13:12], e[11], e[10:7], e[6:0]);
            end
        end
    end

    initial begin
        // Reset with idle inputs
        idle(1'b0, S_RUN, 1'b0, 4'd0);
        idle(1'b0, S_RUN, 1'b0, 4'd0);
        idle(1'b1, S_RUN, 1'b0, 4'd0);

        // Load-use on rs: one-cycle stall, then free
        step(1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_LU, S_RUN, 1'b0, 4'd0);
        idle(1'b1, S_RUN, 1'b0, 4'd1);
        // Load to r0 never stalls
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, O_RUN, S_RUN, 1'b0, 4'd1);
        idle(1'b1, S_RUN, 1'b0, 4'd1);
        // Load-use through rt, then the same registers with id_uses_rt=0
        step(1'b1, 5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, O_LU, S_RUN, 1'b0, 4'd1);
        step(1'b1, 5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, O_RUN, S_RUN, 1'b0, 4'd2);
        // Branch together with a load-use hazard
        step(1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, O_BR, S_RUN, 1'b0, 4'd2);
        idle(1'b1, S_RUN, 1'b0, 4'd2);

        // Three wait cycles, then ready
        mem_stall(O_MS, S_RUN, 1'b0, 4'd2);
        mem_stall(O_MS, S_MW, 1'b0, 4'd3);
        mem_stall(O_MS, S_MW, 1'b0, 4'd4);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, O_RUN, S_MW, 1'b0, 4'd5);
        idle(1'b1, S_RUN, 1'b0, 4'd5);
        // Ready cycle with a branch, then with a load-use hazard
        mem_stall(O_MS, S_RUN, 1'b0, 4'd5);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, O_BR, S_MW, 1'b0, 4'd6);
        mem_stall(O_MS, S_RUN, 1'b0, 4'd6);
        step(1'b1, 5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1, 1'b1, O_LU, S_MW, 1'b0, 4'd7);
        idle(1'b1, S_RUN, 1'b0, 4'd8);

        // Timeout after 4 wait cycles, then ERR is held whatever the inputs
        mem_stall(O_MS, S_RUN, 1'b0, 4'd8);
        mem_stall(O_MS, S_MW, 1'b0, 4'd9);
        mem_stall(O_MS, S_MW, 1'b0, 4'd10);
        mem_stall(O_MS, S_MW, 1'b0, 4'd11);
        mem_stall(O_MS, S_ERR, 1'b1, 4'd12);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_MS, S_ERR, 1'b1, 4'd13);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, O_MS, S_ERR, 1'b1, 4'd14);
        mem_stall(O_MS, S_ERR, 1'b1, 4'd15);
        mem_stall(O_MS, S_ERR, 1'b1, 4'd15);
        // Asynchronous reset out of ERR
        idle(1'b0, S_RUN, 1'b0, 4'd0);
        idle(1'b1, S_RUN, 1'b0, 4'd0);

        // 20 MS cycles: the counter saturates at 15
        for (int i = 0; i < 20; i++) begin
            logic [1:0] st;
            st = (i == 0) ? S_RUN : ((i < 4) ? S_MW : S_ERR);
            mem_stall(O_MS, st, (i >= 4), (i > 15) ? 4'd15 : 4'(i));
        end
        idle(1'b0, S_RUN, 1'b0, 4'd0);
        idle(1'b1, S_RUN, 1'b0, 4'd0);

        // Reset in the middle of MEM_WAIT
        mem_stall(O_MS, S_RUN, 1'b0, 4'd0);
        mem_stall(O_MS, S_MW, 1'b0, 4'd1);
        idle(1'b0, S_RUN, 1'b0, 4'd0);
        idle(1'b1, S_RUN, 1'b0, 4'd0);
        idle(1'b1, S_RUN, 1'b0, 4'd0);

        // Final report
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
